// File: rtl/bkm_ctrl.sv
// bkm_ctrl: iteration controller for the BKM step datapath.
// Latches one operation, issues N step requests with a running index,
// feeds each step result back as the next step's input, ORs the step
// flags together and presents the final X/Y with a one-cycle done pulse.

`ifndef FSIZE
`define FSIZE 5
`endif

module bkm_ctrl #(
  parameter int unsigned W     = 64,
  parameter int unsigned N     = 64,
  parameter int unsigned LOG2N = 6
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                srst,
  input  logic                enable,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [1:0]          format,
  input  logic [W-1:0]        X_in,
  input  logic [W-1:0]        Y_in,
  input  logic [W-1:0]        x_in,
  input  logic [W-1:0]        y_in,
  output logic                busy,
  output logic                step_start,
  output logic [LOG2N-1:0]    step_n,
  output logic                step_mode,
  output logic [1:0]          step_format,
  output logic [W-1:0]        step_X,
  output logic [W-1:0]        step_Y,
  output logic [W-1:0]        step_x,
  output logic [W-1:0]        step_y,
  input  logic [W-1:0]        step_X_res,
  input  logic [W-1:0]        step_Y_res,
  input  logic [`FSIZE-1:0]   step_flags,
  input  logic                step_done,
  output logic [W-1:0]        X_out,
  output logic [W-1:0]        Y_out,
  output logic [`FSIZE-1:0]   flags,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LOG2N-1:0]    count;
  logic                mode_q;
  logic [1:0]          format_q;
  logic [W-1:0]        work_X;
  logic [W-1:0]        work_Y;
  logic [W-1:0]        lat_x;
  logic [W-1:0]        lat_y;
  logic [`FSIZE-1:0]   acc;
  logic                last;
  logic                step_ok;

  // Final iteration reached and an accepted (non-aborted) step result.
  always_comb begin
    last    = (count == LOG2N'(N - 1));
    step_ok = (state == S_WAIT) && step_done && !abort;
  end

  // State register; srst has priority over enable.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_IDLE;
    end else if (srst) begin
      state <= S_IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort wins over a same-cycle step_done.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (step_done) begin
          state_nxt = last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, feedback registers, counter, flag accumulator and results.
  // The result registers and done are loaded on the edge that enters DONE, so
  // that X_out/Y_out/flags are already valid during the cycle done is high.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count    <= '0;
      mode_q   <= 1'b0;
      format_q <= '0;
      work_X   <= '0;
      work_Y   <= '0;
      lat_x    <= '0;
      lat_y    <= '0;
      acc      <= '0;
      X_out    <= '0;
      Y_out    <= '0;
      flags    <= '0;
      done     <= 1'b0;
    end else if (srst) begin
      count    <= '0;
      mode_q   <= 1'b0;
      format_q <= '0;
      work_X   <= '0;
      work_Y   <= '0;
      lat_x    <= '0;
      lat_y    <= '0;
      acc      <= '0;
      X_out    <= '0;
      Y_out    <= '0;
      flags    <= '0;
      done     <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        mode_q   <= mode;
        format_q <= format;
        work_X   <= X_in;
        work_Y   <= Y_in;
        lat_x    <= x_in;
        lat_y    <= y_in;
        count    <= '0;
        acc      <= '0;
      end else if (step_ok) begin
        work_X <= step_X_res;
        work_Y <= step_Y_res;
        acc    <= acc | step_flags;
        if (last) begin
          X_out <= step_X_res;
          Y_out <= step_Y_res;
          flags <= acc | step_flags;
          done  <= 1'b1;
        end else begin
          count <= count + LOG2N'(1);
        end
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy        = (state != S_IDLE);
    step_start  = (state == S_ISSUE);
    step_n      = count;
    step_mode   = mode_q;
    step_format = format_q;
    step_X      = work_X;
    step_Y      = work_Y;
    step_x      = lat_x;
    step_y      = lat_y;
  end

endmodule

// File: tb/tb_bkm_ctrl.sv
// Scoreboard bench for bkm_ctrl: directed operations push expected results,
// a monitor pops and compares on every done pulse, and a step-datapath model
// (X+1, Y+2, per-index flags) answers step requests with latency lat.

`ifndef FSIZE
`define FSIZE 5
`endif

module tb_bkm_ctrl;
  localparam int unsigned W     = 64;
  localparam int unsigned N     = 4;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned FS    = `FSIZE;

  logic              clk = 1'b0;
  logic              arst_n, srst, enable, start, abort, mode;
  logic [1:0]        format;
  logic [W-1:0]      X_in, Y_in, x_in, y_in;
  logic              busy, step_start;
  logic [LOG2N-1:0]  step_n;
  logic              step_mode;
  logic [1:0]        step_format;
  logic [W-1:0]      step_X, step_Y, step_x, step_y;
  logic [W-1:0]      step_X_res, step_Y_res;
  logic [FS-1:0]     step_flags;
  logic              step_done;
  logic [W-1:0]      X_out, Y_out;
  logic [FS-1:0]     flags;
  logic              done;

  logic              done_model, stray;
  assign step_done = done_model | stray;

  bkm_ctrl #(.W(W), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
    .start(start), .abort(abort), .mode(mode), .format(format),
    .X_in(X_in), .Y_in(Y_in), .x_in(x_in), .y_in(y_in),
    .busy(busy), .step_start(step_start), .step_n(step_n),
    .step_mode(step_mode), .step_format(step_format),
    .step_X(step_X), .step_Y(step_Y), .step_x(step_x), .step_y(step_y),
    .step_X_res(step_X_res), .step_Y_res(step_Y_res),
    .step_flags(step_flags), .step_done(step_done),
    .X_out(X_out), .Y_out(Y_out), .flags(flags), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [FS-1:0] f;
    int            c;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Operation context shared with the step model and monitor.
  int            start_cyc = 0;
  int            lat = 1;
  int            exp_n = 0;
  bit            chk_timing = 1'b1;
  logic [W-1:0]  op_X, op_Y, op_x, op_y;
  logic          op_mode;
  logic [1:0]    op_fmt;
  logic [FS-1:0] flag_tab [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait expired, got timeout required event (t=%0t)", nm, $time);
  endtask

  // Step datapath model.
  initial begin
    done_model = 1'b0;
    step_X_res = '0;
    step_Y_res = '0;
    step_flags = '0;
    forever begin
      @(negedge clk);
      if (step_start && enable && arst_n && !srst) begin
        chk("step_n", 64'(step_n), 64'(exp_n));
        chk("step_X", step_X, op_X + 64'(exp_n));
        chk("step_Y", step_Y, op_Y + 64'(2 * exp_n));
        chk("step_x", step_x, op_x);
        chk("step_y", step_y, op_y);
        chk("step_mode", 64'(step_mode), 64'(op_mode));
        chk("step_format", 64'(step_format), 64'(op_fmt));
        if (chk_timing)
          chk("issue_cycle", 64'(cyc - start_cyc), 64'(1 + exp_n * (lat + 1)));
        step_X_res = step_X + 64'd1;
        step_Y_res = step_Y + 64'd2;
        step_flags = (exp_n < int'(N)) ? flag_tab[exp_n] : '0;
        exp_n++;
        repeat (lat) @(posedge clk);
        #1 done_model = 1'b1;
        forever begin
          @(posedge clk);
          if (enable) break;
        end
        #1 done_model = 1'b0;
      end
    end
  end

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 required done=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("X_out", X_out, e.x);
        chk("Y_out", Y_out, e.y);
        chk("flags", 64'(flags), 64'(e.f));
        chk("done_cycle", 64'(cyc - start_cyc), 64'(e.c));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic expect_op(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [FS-1:0] f, input int c);
    exp_t e;
    e.x = x; e.y = y; e.f = f; e.c = c;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [W-1:0] X, input logic [W-1:0] Y,
                        input logic [W-1:0] xs, input logic [W-1:0] ys,
                        input logic m, input logic [1:0] fm, input logic ab);
    @(negedge clk);
    op_X = X; op_Y = Y; op_x = xs; op_y = ys; op_mode = m; op_fmt = fm;
    exp_n = 0;
    X_in = X; Y_in = Y; x_in = xs; y_in = ys; mode = m; format = fm;
    start = 1'b1;
    abort = ab;
    @(posedge clk);
    #1;
    start_cyc = cyc - 1;
    start = 1'b0;
    abort = 1'b0;
    X_in = ~X; Y_in = ~Y; x_in = ~xs; y_in = ~ys; mode = ~m; format = ~fm;
  endtask

  task automatic wait_rel(input int k);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc - start_cyc == k) return;
    end
    timeout("wait_rel");
  endtask

  task automatic finish_op(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (i == max) begin
      timeout("completion");
      sb.delete();
    end
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required $finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0; srst = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0;
    mode = 1'b0; format = '0; X_in = '0; Y_in = '0; x_in = '0; y_in = '0;
    stray = 1'b0;
    for (int i = 0; i < int'(N); i++) flag_tab[i] = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_step_start", 64'(step_start), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_step_n", 64'(step_n), 64'd0);
    chk("rst_X_out", X_out, 64'd0);
    chk("rst_Y_out", Y_out, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_step_X", step_X, 64'd0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal run, L=1.
    lat = 1;
    expect_op(64'd14, 64'd28, '0, 9);
    launch(64'd10, 64'd20, 64'd5, 64'd6, 1'b1, 2'b10, 1'b0);
    wait_rel(1);
    chk("busy_rise", 64'(busy), 64'd1);
    finish_op(60);

    // Flag accumulation with a start pulse while busy.
    flag_tab[1] = 5'b00001;
    flag_tab[3] = 5'b00100;
    expect_op(64'h1004, 64'h2008, 5'b00101, 9);
    launch(64'h1000, 64'h2000, 64'h33, 64'h44, 1'b0, 2'b01, 1'b0);
    wait_rel(3);
    X_in = 64'd999; Y_in = 64'd999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(60);
    flag_tab[1] = '0;
    flag_tab[3] = '0;

    // L=3 with stray step_done in IDLE and ISSUE.
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(negedge clk);
    chk("stray_idle_busy", 64'(busy), 64'd0);
    lat = 3;
    expect_op(64'd14, 64'd28, '0, 17);
    launch(64'd10, 64'd20, 64'd5, 64'd6, 1'b1, 2'b11, 1'b0);
    wait_rel(5); stray = 1'b1;
    wait_rel(6); stray = 1'b0;
    finish_op(80);

    // Abort in WAIT of n=2 (step_done in the same cycle is discarded).
    lat = 1;
    launch(64'd100, 64'd200, 64'd1, 64'd2, 1'b0, 2'b00, 1'b0);
    wait_rel(6); abort = 1'b1;
    wait_rel(7); abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_step_start", 64'(step_start), 64'd0);
    chk("abort_X_out", X_out, 64'd14);
    chk("abort_Y_out", Y_out, 64'd28);
    repeat (8) @(negedge clk);

    // Enable low for 5 cycles mid-WAIT with step_done held.
    chk_timing = 1'b0;
    expect_op(64'd54, 64'd68, '0, 14);
    launch(64'd50, 64'd60, 64'd7, 64'd8, 1'b1, 2'b01, 1'b0);
    wait_rel(4); enable = 1'b0;
    wait_rel(9); enable = 1'b1;
    finish_op(60);
    chk_timing = 1'b1;

    // Asynchronous reset in WAIT.
    launch(64'd7, 64'd8, 64'd9, 64'd10, 1'b0, 2'b10, 1'b0);
    wait_rel(2);
    arst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_X_out", X_out, 64'd0);
    chk("arst_Y_out", Y_out, 64'd0);
    chk("arst_step_X", step_X, 64'd0);
    chk("arst_step_x", step_x, 64'd0);
    @(negedge clk);
    @(negedge clk); arst_n = 1'b1;
    repeat (3) @(negedge clk);

    // New start after arst, with abort in IDLE (no effect).
    expect_op(64'd11, 64'd16, '0, 9);
    launch(64'd7, 64'd8, 64'd9, 64'd10, 1'b0, 2'b10, 1'b1);
    finish_op(60);

    // Synchronous reset in ISSUE.
    launch(64'd30, 64'd40, 64'd1, 64'd1, 1'b1, 2'b00, 1'b0);
    wait_rel(1);
    srst = 1'b1;
    @(posedge clk);
    #1;
    chk("srst_busy", 64'(busy), 64'd0);
    chk("srst_step_start", 64'(step_start), 64'd0);
    chk("srst_X_out", X_out, 64'd0);
    chk("srst_Y_out", Y_out, 64'd0);
    @(negedge clk); srst = 1'b0;
    repeat (4) @(negedge clk);

    // New start after srst.
    flag_tab[0] = 5'b00010;
    expect_op(64'd34, 64'd48, 5'b00010, 9);
    launch(64'd30, 64'd40, 64'd1, 64'd1, 1'b1, 2'b00, 1'b0);
    finish_op(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
